// File: rtl/overflow_range_store_pkg.sv
// overflow_range_store_pkg: shared types and constants for the overflow range store
package overflow_range_store_pkg;

    localparam int BOF_RANGE_DEPTH = 8;
    localparam int BOF_ADDR_W      = 32;

    typedef struct packed {
        logic                  valid;
        logic [BOF_ADDR_W-1:0] first;
        logic [BOF_ADDR_W-1:0] last;
    } range_entry_t;

endpackage

// File: rtl/overflow_range_store_range_cmp.sv
// range_cmp: per-entry lookup hit and write merge (overlap or adjacency) detection
module range_cmp
    import overflow_range_store_pkg::*;
#(
    parameter int AW = BOF_ADDR_W
) (
    input  range_entry_t  entry_i,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] wr_first_i,
    input  logic [AW-1:0] wr_last_i,
    output logic          contains_o,
    output logic          mergeable_o
);

    logic [AW:0] last_p1;
    logic [AW:0] wr_last_p1;

    // one extra bit so the all-ones address plus one does not wrap to zero
    assign last_p1    = {1'b0, entry_i.last} + (AW+1)'(1);
    assign wr_last_p1 = {1'b0, wr_last_i} + (AW+1)'(1);

    assign contains_o  = entry_i.valid && (entry_i.first <= addr_i) && (addr_i <= entry_i.last);
    assign mergeable_o = entry_i.valid && ({1'b0, wr_first_i} <= last_p1) &&
                         (wr_last_p1 >= {1'b0, entry_i.first});

endmodule

// File: rtl/overflow_range_store.sv
// overflow_range_store: circular store of overflow address ranges with merging and same-cycle lookup
module overflow_range_store
    import overflow_range_store_pkg::*;
#(
    parameter int DEPTH = BOF_RANGE_DEPTH,
    parameter int AW    = BOF_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_first_i,
    input  logic [AW-1:0]            wr_last_i,
    input  logic [AW-1:0]            find_addr_i,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] hit_idx_o,
    output logic [AW-1:0]            rd_first_o,
    output logic [AW-1:0]            rd_last_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overwrite_o,
    output logic                     wr_err_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    range_entry_t   ent_q [DEPTH];
    range_entry_t   ent_d [DEPTH];
    logic [IW-1:0]  head_q, head_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_first_q, rd_first_d;
    logic [AW-1:0]  rd_last_q, rd_last_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;
    logic [DEPTH-1:0] contains;
    logic [DEPTH-1:0] mergeable;
    logic [IW-1:0]  merge_idx;
    logic [AW-1:0]  merged_first;
    logic [AW-1:0]  merged_last;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        range_cmp #(.AW(AW)) u_cmp (
            .entry_i     (ent_q[g]),
            .addr_i      (find_addr_i),
            .wr_first_i  (wr_first_i),
            .wr_last_i   (wr_last_i),
            .contains_o  (contains[g]),
            .mergeable_o (mergeable[g])
        );
    end

    // lowest-index priority encoders for the lookup hit and the merge target
    always_comb begin
        hit_idx_o = '0;
        merge_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (contains[i])  hit_idx_o = IW'(i);
            if (mergeable[i]) merge_idx = IW'(i);
        end
    end

    assign hit_o        = |contains;
    assign merged_first = (wr_first_i < ent_q[merge_idx].first) ? wr_first_i : ent_q[merge_idx].first;
    assign merged_last  = (wr_last_i > ent_q[merge_idx].last) ? wr_last_i : ent_q[merge_idx].last;

    // clear beats write; malformed writes only pulse the error; else merge or allocate at head
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        count_d    = count_q;
        rd_first_d = rd_first_q;
        rd_last_d  = rd_last_q;
        ovf_d      = 1'b0;
        err_d      = 1'b0;
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            head_d     = '0;
            count_d    = '0;
            rd_first_d = '0;
            rd_last_d  = '0;
        end else if (wr_en_i) begin
            if (wr_last_i < wr_first_i) begin
                err_d = 1'b1;
            end else if (|mergeable) begin
                ent_d[merge_idx].first = merged_first;
                ent_d[merge_idx].last  = merged_last;
                rd_first_d             = merged_first;
                rd_last_d              = merged_last;
            end else begin
                ent_d[head_q] = {1'b1, wr_first_i, wr_last_i};
                head_d        = head_q + 1'b1;
                ovf_d         = (count_q == CW'(DEPTH));
                count_d       = ovf_d ? count_q : count_q + 1'b1;
                rd_first_d    = wr_first_i;
                rd_last_d     = wr_last_i;
            end
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q     <= '0;
            count_q    <= '0;
            rd_first_q <= '0;
            rd_last_q  <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            count_q    <= count_d;
            rd_first_q <= rd_first_d;
            rd_last_q  <= rd_last_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign rd_first_o  = rd_first_q;
    assign rd_last_o   = rd_last_q;
    assign count_o     = count_q;
    assign overwrite_o = ovf_q;
    assign wr_err_o    = err_q;

endmodule
